// File: rtl/shift_unit.sv
// Multi-cycle shifter/rotator: five shift/rotate modes, up to STEP bits per cycle,
// start/done handshake with a registered result, carry-out and illegal-op flag.
module shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int AW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_operand,
    input  logic [AW-1:0]    i_amount,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_illegal
);
    localparam logic [2:0] OP_SHR  = 3'd0;
    localparam logic [2:0] OP_SHRA = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;

    // Step and width need one extra bit: STEP may equal WIDTH.
    localparam logic [AW:0] L_STEP = (AW+1)'(STEP);
    localparam logic [AW:0] L_W    = (AW+1)'(WIDTH);
    localparam logic [AW:0] L_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_work;
    logic [2:0]       r_op;
    logic [AW-1:0]    r_rem;
    logic             r_carry;
    logic             r_illegal;

    logic             w_legal;
    logic [AW:0]      w_k;
    logic [AW-1:0]    w_rt_idx;
    logic [AW-1:0]    w_lt_idx;
    logic [WIDTH-1:0] w_shifted;
    logic             w_cout;

    assign w_legal = (r_op <= OP_ROL);

    always_ff @(posedge i_clk) begin
        if (i_clear) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_SHIFT;
            S_SHIFT: if (!w_legal || r_rem == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // One step of k = min(STEP, remaining) bits; carry is the last bit across the edge.
    always_comb begin
        w_k       = ({1'b0, r_rem} > L_STEP) ? L_STEP : {1'b0, r_rem};
        w_rt_idx  = AW'(w_k - L_ONE);
        w_lt_idx  = AW'(L_W - w_k);
        w_shifted = r_work;
        w_cout    = 1'b0;
        case (r_op)
            OP_SHR: begin
                w_shifted = r_work >> w_k;
                w_cout    = r_work[w_rt_idx];
            end
            OP_SHRA: begin
                w_shifted = $signed(r_work) >>> w_k;
                w_cout    = r_work[w_rt_idx];
            end
            OP_SHL: begin
                w_shifted = r_work << w_k;
                w_cout    = r_work[w_lt_idx];
            end
            OP_ROR: begin
                w_shifted = (r_work >> w_k) | (r_work << (L_W - w_k));
                w_cout    = r_work[w_rt_idx];
            end
            OP_ROL: begin
                w_shifted = (r_work << w_k) | (r_work >> (L_W - w_k));
                w_cout    = r_work[w_lt_idx];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_work    <= '0;
            r_op      <= '0;
            r_rem     <= '0;
            r_carry   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_work    <= i_operand;
                    r_op      <= i_op;
                    r_rem     <= i_amount;
                    r_carry   <= 1'b0;
                    r_illegal <= 1'b0;
                end
                S_SHIFT: begin
                    if (!w_legal) begin
                        r_illegal <= 1'b1;
                    end else if (r_rem != '0) begin
                        r_work  <= w_shifted;
                        r_rem   <= r_rem - AW'(w_k);
                        r_carry <= w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_result  = r_work;
    assign o_carry   = r_carry;
    assign o_illegal = r_illegal;
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = (r_state == S_DONE);
endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: STEP=1 and STEP=4 instances, directed table, hand
// sequences for held start and mid-operation clear, and a random sweep vs a bit-serial model.
module tb_shift_unit;
    logic        clk;
    logic        clear;
    logic        start    [2];
    logic [2:0]  op       [2];
    logic [31:0] operand  [2];
    logic [4:0]  amount   [2];
    logic [31:0] result   [2];
    logic        carry    [2];
    logic        busy     [2];
    logic        done     [2];
    logic        illegal  [2];

    int n_vec = 0;
    int n_err = 0;

    shift_unit #(.WIDTH(32), .STEP(1)) u_s1 (
        .i_clk(clk), .i_clear(clear), .i_start(start[0]), .i_op(op[0]),
        .i_operand(operand[0]), .i_amount(amount[0]), .o_result(result[0]),
        .o_carry(carry[0]), .o_busy(busy[0]), .o_done(done[0]), .o_illegal(illegal[0])
    );

    shift_unit #(.WIDTH(32), .STEP(4)) u_s4 (
        .i_clk(clk), .i_clear(clear), .i_start(start[1]), .i_op(op[1]),
        .i_operand(operand[1]), .i_amount(amount[1]), .o_result(result[1]),
        .o_carry(carry[1]), .o_busy(busy[1]), .o_done(done[1]), .o_illegal(illegal[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          d;
        logic [2:0]  op;
        logic [31:0] v;
        logic [4:0]  amt;
        logic [31:0] res;
        logic        c;
        logic        ill;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    // Bit-at-a-time model: apply the mode `amt` times, carry is the last bit out.
    function automatic void model(input logic [2:0] m, input logic [31:0] v, input int amt,
                                  output logic [31:0] r, output logic c);
        r = v;
        c = 1'b0;
        if (m > 3'd4) return;
        for (int i = 0; i < amt; i++) begin
            case (m)
                3'd0: begin c = r[0];  r = {1'b0, r[31:1]};  end
                3'd1: begin c = r[0];  r = {r[31], r[31:1]}; end
                3'd2: begin c = r[31]; r = {r[30:0], 1'b0};  end
                3'd3: begin c = r[0];  r = {r[0], r[31:1]};  end
                default: begin c = r[31]; r = {r[30:0], r[31]}; end
            endcase
        end
    endfunction

    // Issue one request, return outputs at the done pulse, latency in edges, and result one cycle later.
    task automatic run(input int d, input logic [2:0] m, input logic [31:0] v, input logic [4:0] amt,
                       output logic [31:0] res, output logic c, output logic ill,
                       output int lat, output logic [31:0] held);
        @(negedge clk);
        start[d] = 1'b1; op[d] = m; operand[d] = v; amount[d] = amt;
        @(posedge clk);
        #1 start[d] = 1'b0;
        lat = -1; res = '0; c = 1'b0; ill = 1'b0; held = '0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done[d]) begin
                lat = i; res = result[d]; c = carry[d]; ill = illegal[d];
                break;
            end
        end
        @(posedge clk);
        #1 held = result[d];
    endtask

    vec_t        tbl [10];
    logic [31:0] r_res, r_held, m_res;
    logic        r_c, r_ill, m_c;
    int          r_lat;

    initial begin
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; op[d] = '0; operand[d] = '0; amount[d] = '0;
        end
        clear = 1'b1;
        tbl[0] = '{0, 3'd1, 32'hFFFFFFF4, 5'd5,  32'hFFFFFFFF, 1'b1, 1'b0, 6};
        tbl[1] = '{0, 3'd2, 32'h80000001, 5'd1,  32'h00000002, 1'b1, 1'b0, 2};
        tbl[2] = '{0, 3'd0, 32'h00000005, 5'd0,  32'h00000005, 1'b0, 1'b0, 1};
        tbl[3] = '{1, 3'd3, 32'h00000001, 5'd4,  32'h10000000, 1'b0, 1'b0, 2};
        tbl[4] = '{1, 3'd4, 32'h80000000, 5'd7,  32'h00000040, 1'b0, 1'b0, 3};
        tbl[5] = '{0, 3'd7, 32'hDEADBEEF, 5'd9,  32'hDEADBEEF, 1'b0, 1'b1, 1};
        tbl[6] = '{0, 3'd0, 32'h000000F0, 5'd4,  32'h0000000F, 1'b0, 1'b0, 5};
        tbl[7] = '{1, 3'd1, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 9};
        tbl[8] = '{1, 3'd2, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0, 9};
        tbl[9] = '{1, 3'd3, 32'h0000000F, 5'd3,  32'hE0000001, 1'b1, 1'b0, 2};

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset result d%0d", d), result[d], 32'h0);
            chk($sformatf("reset flags d%0d", d),
                {28'h0, carry[d], busy[d], done[d], illegal[d]}, 32'h0);
        end
        clear = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run(tbl[i].d, tbl[i].op, tbl[i].v, tbl[i].amt, r_res, r_c, r_ill, r_lat, r_held);
            chk($sformatf("row%0d result", i),  r_res, tbl[i].res);
            chk($sformatf("row%0d carry", i),   {31'h0, r_c}, {31'h0, tbl[i].c});
            chk($sformatf("row%0d illegal", i), {31'h0, r_ill}, {31'h0, tbl[i].ill});
            chk($sformatf("row%0d latency", i), r_lat, tbl[i].lat);
            chk($sformatf("row%0d held", i),    r_held, tbl[i].res);
        end

        // start held high through a whole operation
        begin
            int ndone = 0, dedge = -1;
            logic b10 = 1'b1, b11 = 1'b0;
            logic [31:0] dres = '0;
            @(negedge clk);
            start[0] = 1'b1; op[0] = 3'd0; operand[0] = 32'h100; amount[0] = 5'd8;
            @(posedge clk);
            for (int e = 1; e <= 11; e++) begin
                @(posedge clk);
                #1;
                if (done[0] && e <= 10) begin ndone++; dedge = e; dres = result[0]; end
                if (e == 10) b10 = busy[0];
                if (e == 11) b11 = busy[0];
            end
            start[0] = 1'b0;
            chk("held-start done count", ndone, 1);
            chk("held-start done edge", dedge, 9);
            chk("held-start result", dres, 32'h1);
            chk("held-start busy@10", {31'h0, b10}, 32'h0);
            chk("held-start busy@11", {31'h0, b11}, 32'h1);
            for (int e = 0; e < 20; e++) begin
                @(posedge clk);
                #1;
                if (done[0]) break;
            end
            @(posedge clk);
            #1;
        end

        // clear at edge 3 of a SHRA by 20
        begin
            int spurious = 0;
            @(negedge clk);
            start[0] = 1'b1; op[0] = 3'd1; operand[0] = 32'h80000000; amount[0] = 5'd20;
            @(posedge clk);
            #1 start[0] = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #1 clear = 1'b1;
            @(posedge clk);
            #1;
            chk("clear result", result[0], 32'h0);
            chk("clear flags", {28'h0, carry[0], busy[0], done[0], illegal[0]}, 32'h0);
            clear = 1'b0;
            for (int e = 0; e < 30; e++) begin
                @(posedge clk);
                #1;
                if (done[0]) spurious++;
            end
            chk("clear no done", spurious, 0);
            run(0, 3'd1, 32'h80000000, 5'd20, r_res, r_c, r_ill, r_lat, r_held);
            chk("post-clear result", r_res, 32'hFFFFF800);
            chk("post-clear latency", r_lat, 21);
        end

        for (int i = 0; i < 60; i++) begin
            int d, stp, elat;
            logic [2:0]  m;
            logic [31:0] v;
            logic [4:0]  a;
            d = int'($urandom_range(0, 1));
            stp = (d == 1) ? 4 : 1;
            m = 3'($urandom_range(0, 5));
            v = $urandom;
            a = 5'($urandom_range(0, 31));
            model(m, v, int'(a), m_res, m_c);
            elat = (m > 3'd4 || a == 0) ? 1 : (int'(a) + stp - 1) / stp + 1;
            run(d, m, v, a, r_res, r_c, r_ill, r_lat, r_held);
            chk($sformatf("rnd%0d op%0d amt%0d result", i, m, a), r_res, m_res);
            chk($sformatf("rnd%0d carry", i), {31'h0, r_c}, {31'h0, m_c});
            chk($sformatf("rnd%0d illegal", i), {31'h0, r_ill}, {31'h0, (m > 3'd4)});
            chk($sformatf("rnd%0d latency", i), r_lat, elat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/shift_unit.md
# shift_unit

Multi-cycle shifter/rotator for the mini CPU datapath, generalising the single arithmetic-right-shift ALU path to five shift/rotate modes, parametrised width and parametrised bits-per-cycle. It takes an operand and shift amount on a start pulse and iterates internally. It returns a registered result, which the control sequencer moves to Zlow, plus a carry flag, which goes to Zhigh bit 0, under a start/done handshake.

## Interface
- WIDTH, 32: operand/result width in bits; power of two, ≥ 8.
- STEP, 1: maximum bits shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH.
- AW, $clog2(WIDTH): shift-amount width (derived, not overridden).

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  reset; synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  3  mode:
  - 000 SHR (logical right)
  - 001 SHRA (arithmetic right)
  - 010 SHL
  - 011 ROR
  - 100 ROL
  - 101–111 illegal
- operand  in  WIDTH  value to shift; captured with start.
- amount  in  AW  shift count 0..WIDTH-1; captured with start.
- result  out  WIDTH  shifted value; valid while done=1, held until next accepted start.
- carry  out  1  last bit shifted or rotated out; 0 for amount 0 or illegal op.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  high with done when the captured op was illegal; held with result.

## Operation
- States:
  - IDLE: waits for start.
  - SHIFT: iterates the shift.
  - DONE: asserts done.
- IDLE: if start=1, capture operand into the work register, and capture op and amount into remaining. Clear carry and illegal, then go to SHIFT. If start=0, stay in IDLE.
- SHIFT with remaining>0 and a legal op:
  - Shift the work register by k = min(STEP, remaining) in the captured mode.
  - Set remaining -= k.
  - Set carry = the last bit to leave the boundary in that step:
    - right modes: bit k-1 before the step
    - left modes: bit WIDTH-k before the step
- Per-mode fill rules:
  - SHR fills with 0.
  - SHRA fills with the original sign bit.
  - SHL fills with 0.
  - ROR and ROL wrap bits around.
  - For rotates, carry equals the bit that wrapped last.
- SHIFT with remaining=0: go to DONE.
- SHIFT with an illegal op: no shift, set illegal=1, go to DONE.
- DONE: done=1 and result = work register. Go to IDLE on the next edge.
- start while busy=1 (in SHIFT or DONE) is ignored, not queued.
- result and carry are driven from registers and may change during SHIFT; consumers sample them only when done=1.
- Width rules:
  - Amount is unsigned.
  - Amounts ≥ WIDTH are impossible by port width.
  - Amount 0 passes operand through unchanged with carry=0.

## Timing
- Reset (clear=1 at an edge) sets:
  - state to IDLE
  - result to 0, carry to 0
  - busy to 0, done to 0, illegal to 0
  - remaining to 0
- clear wins over start on the same edge.
- Reset during SHIFT or DONE aborts the operation; done is never asserted for the aborted request.
- Latency: call the edge that accepts start edge 0, and let N = ceil(amount/STEP).
  - Edges 1..N perform the shifts.
  - Edge N+1 enters DONE; done is high for the following cycle.
  - Edge N+2 returns to IDLE.
  - Amount 0 or an illegal op: done is high after edge 1.
- busy rises after edge 0 and falls after edge N+2, so the earliest next start is accepted at edge N+2+1.

## Test plan
- WIDTH=32, STEP=1: SHRA, operand 0xFFFFFFF4 (-12), amount 5 → done after edge 6, result 0xFFFFFFFF, carry 1, illegal 0.
- WIDTH=32, STEP=1: SHL, operand 0x80000001, amount 1 → done after edge 2, result 0x00000002, carry 1. Then SHR, operand 0x00000005, amount 0 → done after edge 1, result 0x00000005, carry 0.
- WIDTH=32, STEP=4: ROR, operand 0x00000001, amount 4 → done after edge 2, result 0x10000000, carry 0. Then ROL, operand 0x80000000, amount 7 → steps 4+3, done after edge 3, result 0x00000040, carry 0.
- Illegal op 3'b111, operand 0xDEADBEEF → done after edge 1, result 0xDEADBEEF, carry 0, illegal 1. The next legal request clears illegal.
- start held high through SHR, operand 0x100, amount 8 (STEP=1) → exactly one done pulse (after edge 9), result 0x1. The held start is next accepted at the edge where busy=0.
- clear asserted at edge 3 of a SHRA by 20 → all outputs 0 after that edge, no done pulse. A fresh request afterwards completes normally.
